// File: rtl/ab_ff_bank.sv
// Bank of AB flip-flops with parallel load, a change flag and a saturating change counter.
// Optional history buffer of pre-update states is enabled by defining AB_FF_HIST_EN.
module ab_ff_bank #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     load,
  input  logic [WIDTH-1:0]         d,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic [WIDTH-1:0]         q,
  output logic                     changed,
  output logic [CNT_W-1:0]         chg_cnt
`ifdef AB_FF_HIST_EN
  ,
  input  logic [$clog2(DEPTH)-1:0] hist_sel,
  output logic [WIDTH-1:0]         hist_q
`endif
);

  // Elaboration-time guard: a zero-entry history makes no sense in either build.
  if (DEPTH < 1) begin : g_bad_depth
    $error("ab_ff_bank: DEPTH must be at least 1");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] ab_next;
  logic [WIDTH-1:0] q_next;
  logic             update;
  logic             differs;

  // NOTE: every always_comb output gets a default assignment first so no path can infer a latch.
  always_comb begin
    ab_next = (~a & ~b & q) | (a & b) | (a & ~q);
    q_next  = q;
    if (load) begin
      q_next = d;
    end else if (en) begin
      q_next = ab_next;
    end
  end

  assign update  = load | en;
  assign differs = update && (q_next != q);

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      changed <= 1'b0;
      chg_cnt <= '0;
    end else if (update) begin
      q       <= q_next;
      changed <= differs;
      if (differs && (chg_cnt != CNT_MAX)) begin
        chg_cnt <= chg_cnt + CNT_W'(1);
      end
    end
  end

`ifdef AB_FF_HIST_EN
  logic [WIDTH-1:0] hist [DEPTH];

  // NOTE: the history array is reset explicitly because reset must clear every entry, not just q.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist[i] <= '0;
      end
    end else if (differs) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        hist[i] <= hist[i-1];
      end
      hist[0] <= q;
    end
  end

  // Out-of-range selects read as zero when DEPTH is not a power of two.
  always_comb begin
    hist_q = '0;
    if (32'(hist_sel) < DEPTH) begin
      hist_q = hist[hist_sel];
    end
  end
`endif

endmodule

// File: tb/tb_ab_ff_bank.sv
// Scoreboard bench for ab_ff_bank: one 16-bit-counter instance and one 2-bit-counter instance share stimulus.
// History checks are compiled in when AB_FF_HIST_EN is defined.
module tb_ab_ff_bank;

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [7:0] d, a, b;
  logic [7:0] q, q2;
  logic       changed, changed2;
  logic [15:0] chg_cnt;
  logic [1:0]  chg_cnt2;
`ifdef AB_FF_HIST_EN
  logic [1:0] hist_sel;
  logic [7:0] hist_q, hist_q2;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  q;
    logic        changed;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    string       tag;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [7:0]  m_q;
  logic        m_changed;
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt2;
  logic [7:0]  m_hist[4];

  always #5 clk = ~clk;

  ab_ff_bank #(.WIDTH(8), .CNT_W(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .d(d), .a(a), .b(b),
    .q(q), .changed(changed), .chg_cnt(chg_cnt)
`ifdef AB_FF_HIST_EN
    , .hist_sel(hist_sel), .hist_q(hist_q)
`endif
  );

  ab_ff_bank #(.WIDTH(8), .CNT_W(2), .DEPTH(4)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .load(load), .d(d), .a(a), .b(b),
    .q(q2), .changed(changed2), .chg_cnt(chg_cnt2)
`ifdef AB_FF_HIST_EN
    , .hist_sel(hist_sel), .hist_q(hist_q2)
`endif
  );

  // Command table: 00 hold, 01 clear, 10 toggle, 11 set.
  function automatic logic [7:0] ab_model(input logic [7:0] cur, input logic [7:0] aa,
                                          input logic [7:0] bb);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      case ({aa[i], bb[i]})
        2'b00:   r[i] = cur[i];
        2'b01:   r[i] = 1'b0;
        2'b10:   r[i] = ~cur[i];
        default: r[i] = 1'b1;
      endcase
    end
    return r;
  endfunction

  // Drive one cycle of stimulus, push the expected result, then pop and compare after the edge.
  task automatic cycle(input logic r, input logic l, input logic e, input logic [7:0] dd,
                       input logic [7:0] aa, input logic [7:0] bb, input string tag);
    exp_t       ex;
    exp_t       got;
    logic [7:0] nq;
    rst = r; load = l; en = e; d = dd; a = aa; b = bb;
    if (r) begin
      m_q = '0; m_changed = 1'b0; m_cnt = '0; m_cnt2 = '0;
      for (int i = 0; i < 4; i++) m_hist[i] = '0;
    end else if (l || e) begin
      nq = l ? dd : ab_model(m_q, aa, bb);
      m_changed = (nq !== m_q);
      if (m_changed) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
        for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = m_q;
      end
      m_q = nq;
    end
    ex.q = m_q; ex.changed = m_changed; ex.cnt = m_cnt; ex.cnt2 = m_cnt2; ex.tag = tag;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    total++;
    if (q !== got.q) begin
      bad++; $display("FAIL %s q: got %h want %h", got.tag, q, got.q);
    end
    total++;
    if (changed !== got.changed) begin
      bad++; $display("FAIL %s changed: got %b want %b", got.tag, changed, got.changed);
    end
    total++;
    if (chg_cnt !== got.cnt) begin
      bad++; $display("FAIL %s chg_cnt: got %0d want %0d", got.tag, chg_cnt, got.cnt);
    end
    total++;
    if (chg_cnt2 !== got.cnt2) begin
      bad++; $display("FAIL %s chg_cnt_sat: got %0d want %0d", got.tag, chg_cnt2, got.cnt2);
    end
    rst = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1, 1, 1, 8'hFF, 8'hFF, 8'hFF, "reset1");
    cycle(1, 1, 0, 8'hFF, 8'h00, 8'h00, "reset2");
    total++;
    if (q !== 8'h00 || changed !== 1'b0 || chg_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_state: got q=%h chg=%b cnt=%0d want 00/0/0", q, changed, chg_cnt);
    end
  endtask

  task automatic test_commands();
    cycle(0, 0, 1, 8'h00, 8'hF0, 8'hCC, "cmd1");
    total++;
    if (q !== 8'hF0 || changed !== 1'b1) begin
      bad++; $display("FAIL cmd1_const: got q=%h chg=%b want f0/1", q, changed);
    end
    cycle(0, 0, 1, 8'h00, 8'hF0, 8'hCC, "cmd2");
    total++;
    if (q !== 8'hC0 || chg_cnt !== 16'd2) begin
      bad++; $display("FAIL cmd2_const: got q=%h cnt=%0d want c0/2", q, chg_cnt);
    end
  endtask

  task automatic test_priority();
    cycle(0, 1, 1, 8'h5A, 8'hFF, 8'h00, "priority");
    total++;
    if (q !== 8'h5A || changed !== 1'b1 || chg_cnt !== 16'd3) begin
      bad++; $display("FAIL priority_const: got q=%h chg=%b cnt=%0d want 5a/1/3", q, changed, chg_cnt);
    end
  endtask

  task automatic test_no_change();
    cycle(0, 0, 1, 8'h00, 8'h00, 8'h00, "nochg_hold_cmd");
    cycle(0, 1, 0, 8'h5A, 8'h00, 8'h00, "nochg_load_same");
    total++;
    if (changed !== 1'b0 || chg_cnt !== 16'd3) begin
      bad++; $display("FAIL nochg_const: got chg=%b cnt=%0d want 0/3", changed, chg_cnt);
    end
    // changed must hold its 1 through idle cycles with random a/b
    cycle(0, 0, 1, 8'h00, 8'h01, 8'h00, "toggle_bit0");
    cycle(0, 0, 0, 8'hAA, 8'hFF, 8'h55, "idle1");
    cycle(0, 0, 0, 8'h33, 8'h0F, 8'hF0, "idle2");
    total++;
    if (q !== 8'h5B || changed !== 1'b1 || chg_cnt !== 16'd4) begin
      bad++; $display("FAIL idle_hold_const: got q=%h chg=%b cnt=%0d want 5b/1/4", q, changed, chg_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      cycle(0, ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0),
            8'($urandom), 8'($urandom), 8'($urandom), "random");
    end
  endtask

  task automatic test_back_to_back();
    cycle(0, 1, 0, 8'h3C, 8'h00, 8'h00, "b2b_load");
    cycle(0, 0, 1, 8'h00, 8'hFF, 8'h00, "b2b_toggle");
    cycle(1, 1, 1, 8'hFF, 8'hFF, 8'hFF, "b2b_midreset");
    total++;
    if (q !== 8'h00 || changed !== 1'b0 || chg_cnt !== 16'd0 || chg_cnt2 !== 2'd0) begin
      bad++; $display("FAIL midreset_const: got q=%h chg=%b cnt=%0d want 00/0/0", q, changed, chg_cnt);
    end
    cycle(0, 0, 1, 8'h00, 8'hFF, 8'hFF, "b2b_set_after_reset");
  endtask

  task automatic test_saturation();
    cycle(1, 0, 0, 8'h00, 8'h00, 8'h00, "sat_reset");
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 8'h00, 8'h01, 8'h00, "sat_toggle");
    total++;
    if (chg_cnt2 !== 2'd3 || chg_cnt !== 16'd5) begin
      bad++; $display("FAIL sat_const: got sat=%0d wide=%0d want 3/5", chg_cnt2, chg_cnt);
    end
    cycle(0, 0, 1, 8'h00, 8'h01, 8'h00, "sat_stay");
    total++;
    if (chg_cnt2 !== 2'd3) begin
      bad++; $display("FAIL sat_stays: got %0d want 3", chg_cnt2);
    end
  endtask

`ifdef AB_FF_HIST_EN
  task automatic test_history();
    logic [7:0] want[4];
    want[0] = 8'h03; want[1] = 8'h01; want[2] = 8'h00; want[3] = 8'h00;
    cycle(1, 0, 0, 8'h00, 8'h00, 8'h00, "hist_reset");
    cycle(0, 1, 0, 8'h01, 8'h00, 8'h00, "hist_ld1");
    cycle(0, 1, 0, 8'h03, 8'h00, 8'h00, "hist_ld3");
    cycle(0, 1, 0, 8'h07, 8'h00, 8'h00, "hist_ld7");
    for (int i = 0; i < 4; i++) begin
      hist_sel = 2'(i);
      #1;
      total++;
      if (hist_q !== want[i] || hist_q !== m_hist[i]) begin
        bad++; $display("FAIL hist_sel%0d: got %h want %h", i, hist_q, want[i]);
      end
    end
    cycle(1, 0, 0, 8'h00, 8'h00, 8'h00, "hist_clear");
    for (int i = 0; i < 4; i++) begin
      hist_sel = 2'(i);
      #1;
      total++;
      if (hist_q !== 8'h00) begin
        bad++; $display("FAIL hist_clear%0d: got %h want 00", i, hist_q);
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0; d = '0; a = '0; b = '0;
    m_q = '0; m_changed = 1'b0; m_cnt = '0; m_cnt2 = '0;
    for (int i = 0; i < 4; i++) m_hist[i] = '0;
`ifdef AB_FF_HIST_EN
    hist_sel = '0;
`endif
    @(negedge clk);
    test_reset();
    test_commands();
    test_priority();
    test_no_change();
    test_random();
    test_back_to_back();
    test_saturation();
`ifdef AB_FF_HIST_EN
    test_history();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
